chunk_serial_adder: RTL and testbench

//  Parametrised multi-cycle successor to the 4-bit ripple-carry adder built from full-adder cells.

---
 rtl/chunk_serial_adder_pkg.sv | 20 ++
 rtl/chunk_serial_adder_chunk_adder.sv | 40 ++++
 rtl/chunk_serial_adder.sv | 145 ++++++++++++++
 tb/tb_chunk_serial_adder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chunk_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// chunk_serial_adder_pkg
//   Shared definitions for the chunk-serial adder:
//     state_e        - controller states (idle / running chunks / result held)
//     chunk_cfg_ok() - elaboration-time sanity check of WIDTH/CHUNK pairing
// ---------------------------------------------------------------------------
package chunk_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // WIDTH must split into a whole number of non-empty chunks.
  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_serial_adder_chunk_adder.sv
// ---------------------------------------------------------------------------
// chunk_adder
//   Purely combinational CHUNK-bit ripple-carry adder built from full-adder
//   cells.
//   Ports:
//     a_c, b_c  in  CHUNK  operand slices
//     c_in      in  1      carry into bit 0
//     s_c       out CHUNK  sum slice
//     c_out     out 1      carry out of the top bit
//     c_msb_in  out 1      carry into the top bit (used for signed overflow)
// ---------------------------------------------------------------------------
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_c,
  input  logic [CHUNK-1:0] b_c,
  input  logic             c_in,
  output logic [CHUNK-1:0] s_c,
  output logic             c_out,
  output logic             c_msb_in
);

  // The ripple is walked with a scalar carry variable rather than a carry
  // vector so the chain does not look like a self-referencing net.
  always_comb begin
    logic c;
    s_c      = '0;
    c_msb_in = 1'b0;
    c        = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) begin
        c_msb_in = c;
      end
      s_c[i] = a_c[i] ^ b_c[i] ^ c;
      c      = (a_c[i] & b_c[i]) | (c & (a_c[i] ^ b_c[i]));
    end
    c_out = c;
  end

endmodule

// File: rtl/chunk_serial_adder.sv
// ---------------------------------------------------------------------------
// chunk_serial_adder
//   Multi-cycle add/subtract of two WIDTH-bit operands, CHUNK bits per clock,
//   LSB chunk first, with the inter-chunk carry held in a register.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid / in_ready   operand handshake (ready only while idle)
//     a, b, sub, cin        operands; sub=1 computes a-b, else a+b+cin
//     out_valid / out_ready result handshake; result held until out_ready
//     sum, cout, ovf        registered result, carry-out (sub: 1 = no
//                           borrow), two's-complement overflow
// ---------------------------------------------------------------------------
module chunk_serial_adder
  import chunk_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("chunk_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] s_slice;
  logic             c_out;
  logic             c_msb_in;

  assign a_slice = a_q[int'(cnt_q) * CHUNK +: CHUNK];
  assign b_slice = b_q[int'(cnt_q) * CHUNK +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a_c      (a_slice),
    .b_c      (b_slice),
    .c_in     (carry_q),
    .s_c      (s_slice),
    .c_out    (c_out),
    .c_msb_in (c_msb_in)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so B is inverted once at accept and
          // the +1 rides in as the initial carry.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        sum_d[int'(cnt_q) * CHUNK +: CHUNK] = s_slice;
        carry_d = c_out;
        if (cnt_q == LAST_IDX) begin
          cout_d  = c_out;
          ovf_d   = c_msb_in ^ c_out;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_chunk_serial_adder
//   Three instances of the adder (CHUNK = 4, 16, 1; WIDTH = 16) driven from
//   a shared clock and reset. Directed table vectors, back-pressure and
//   mid-run reset sequences, then random add/sub against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_chunk_serial_adder;

  localparam int W = 16;
  localparam int NI = 3;
  localparam int CH [NI] = '{4, 16, 1};

  logic clk;
  logic rst_n;

  logic         in_valid  [NI];
  logic         out_ready [NI];
  logic [W-1:0] a_s       [NI];
  logic [W-1:0] b_s       [NI];
  logic         sub_s     [NI];
  logic         cin_s     [NI];
  logic         in_ready_w  [NI];
  logic         out_valid_w [NI];
  logic [W-1:0] sum_w       [NI];
  logic         cout_w      [NI];
  logic         ovf_w       [NI];

  int n_cmp  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    chunk_serial_adder #(
      .WIDTH (W),
      .CHUNK (CH[gi])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready_w[gi]),
      .a         (a_s[gi]),
      .b         (b_s[gi]),
      .sub       (sub_s[gi]),
      .cin       (cin_s[gi]),
      .out_valid (out_valid_w[gi]),
      .out_ready (out_ready[gi]),
      .sum       (sum_w[gi]),
      .cout      (cout_w[gi]),
      .ovf       (ovf_w[gi])
    );
  end

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         c;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned result for sum/cout, signed result
  // range for overflow.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sv, input logic cv,
                       output logic [W-1:0] e_sum, output logic e_cout,
                       output logic e_ovf);
    int ua, ub, sa, sb, ru, rs;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (sv) begin
      ru     = ua - ub;
      rs     = sa - sb;
      e_cout = (ua >= ub);
    end else begin
      ru     = ua + ub + int'(cv);
      rs     = sa + sb + int'(cv);
      e_cout = (ru > 65535);
    end
    e_sum = ru[W-1:0];
    e_ovf = (rs > 32767) || (rs < -32768);
  endtask

  task automatic check_reset_vals(input int idx, input string tag);
    chk({tag, "_in_ready"},  in_ready_w[idx],  1'b1);
    chk({tag, "_out_valid"}, out_valid_w[idx], 1'b0);
    chk({tag, "_sum"},       sum_w[idx],       16'h0000);
    chk({tag, "_cout"},      cout_w[idx],      1'b0);
    chk({tag, "_ovf"},       ovf_w[idx],       1'b0);
  endtask

  // Issue one operation, scramble the input bus after accept, and wait for
  // the result. Returns the result and the cycles from accept to out_valid.
  task automatic run_op(input int idx, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input logic cv,
                        output logic [W-1:0] sm, output logic co, output logic ov,
                        output int lat);
    int guard;
    guard = 0;
    while (in_ready_w[idx] !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    a_s[idx]      = av;
    b_s[idx]      = bv;
    sub_s[idx]    = sv;
    cin_s[idx]    = cv;
    in_valid[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
    a_s[idx]      = W'($urandom);
    b_s[idx]      = W'($urandom);
    sub_s[idx]    = 1'($urandom);
    cin_s[idx]    = 1'($urandom);
    chk("in_ready_after_accept", in_ready_w[idx], 1'b0);
    lat = 0;
    while (out_valid_w[idx] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    sm = sum_w[idx];
    co = cout_w[idx];
    ov = ovf_w[idx];
    $display("op chunk=%0d a=%h b=%h sub=%0d cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             CH[idx], av, bv, sv, cv, sm, co, ov, lat);
  endtask

  vec_t         vt [5];
  logic [W-1:0] r_sum, e_sum;
  logic         r_cout, r_ovf, e_cout, e_ovf;
  int           lat;

  initial begin
    vt[0] = '{"add_1234_4321",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{"add_ffff_0001",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{"add_7fff_0001",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{"sub_0005_0007",  16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{"sub_8000_0001",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      a_s[i]       = '0;
      b_s[i]       = '0;
      sub_s[i]     = 1'b0;
      cin_s[i]     = 1'b0;
    end

    // Reset
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) check_reset_vals(i, "reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors on the CHUNK=4 instance
    for (int v = 0; v < 5; v++) begin
      run_op(0, vt[v].a, vt[v].b, vt[v].s, vt[v].c, r_sum, r_cout, r_ovf, lat);
      chk({vt[v].name, "_sum"},  r_sum,  vt[v].e_sum);
      chk({vt[v].name, "_cout"}, r_cout, vt[v].e_cout);
      chk({vt[v].name, "_ovf"},  r_ovf,  vt[v].e_ovf);
      chk({vt[v].name, "_lat"},  lat,    32'd4);
    end

    // Back-pressure: result held with out_ready low, in_valid held high
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk("bp_idle_ready", in_ready_w[0], 1'b1);
    a_s[0] = 16'h1234; b_s[0] = 16'h4321; sub_s[0] = 1'b0; cin_s[0] = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    a_s[0] = 16'h0001; b_s[0] = 16'h0002;
    repeat (4) begin @(posedge clk); #1; end
    chk("bp_valid_first", out_valid_w[0], 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid_w[0], 1'b1);
      chk("bp_hold_sum",   sum_w[0],       16'h5555);
      chk("bp_hold_ready", in_ready_w[0],  1'b0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid_w[0], 1'b0);
    chk("bp_release_ready", in_ready_w[0],  1'b1);
    @(posedge clk); #1;
    chk("bp_next_accepted", in_ready_w[0], 1'b0);
    in_valid[0] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("bp_next_valid", out_valid_w[0], 1'b1);
    chk("bp_next_sum",   sum_w[0],       16'h0003);
    $display("op chunk=4 back-pressure sequence: second result sum=%h", sum_w[0]);
    @(posedge clk); #1;

    // Reset during the second RUN cycle
    a_s[0] = 16'hFFFF; b_s[0] = 16'h0001; sub_s[0] = 1'b0; cin_s[0] = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals(0, "midrun_reset");
    #1 rst_n = 1'b1;
    run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, r_sum, r_cout, r_ovf, lat);
    chk("post_reset_sum",  r_sum,  16'h0002);
    chk("post_reset_cout", r_cout, 1'b0);
    chk("post_reset_ovf",  r_ovf,  1'b0);
    chk("post_reset_lat",  lat,    32'd4);

    // Random add/sub on all three chunkings
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 30; n++) begin
        logic [W-1:0] ra, rb;
        logic         rs, rc;
        ra = W'($urandom);
        rb = W'($urandom);
        if (n % 5 == 0) rb = W'(16'h8000 - 16'(n));
        rs = 1'($urandom);
        rc = 1'($urandom);
        model(ra, rb, rs, rc, e_sum, e_cout, e_ovf);
        run_op(i, ra, rb, rs, rc, r_sum, r_cout, r_ovf, lat);
        chk("rand_sum",  r_sum,  e_sum);
        chk("rand_cout", r_cout, e_cout);
        chk("rand_ovf",  r_ovf,  e_ovf);
        chk("rand_lat",  lat,    32'(W / CH[i]));
      end
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
